// File: rtl/mips_pipe_pkg.sv
// Shared constants for the MIPS pipeline hazard/stall controller:
// forwarding select encodings, MDU sequencer states and the zero register.
package mips_pipe_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdu_state_t;

endpackage

// File: rtl/hazard_stall_controller_if.sv
// Signal bundle between the ID-stage datapath and the hazard/stall controller.
// STALL_COUNT exists only when STALL_COUNTER_EN is defined.
interface hazard_stall_controller_if;

    logic [4:0]  ID_RS;
    logic [4:0]  ID_RT;
    logic        ID_USES_RS;
    logic        ID_USES_RT;
    logic        ID_READS_HILO;
    logic        ID_MDU_START;
    logic        ID_MDU_DIV;
    logic [4:0]  EX_DEST;
    logic        EX_RF_ENABLE;
    logic        EX_LOAD_INSTR;
    logic [4:0]  MEM_DEST;
    logic        MEM_RF_ENABLE;
    logic [4:0]  WB_DEST;
    logic        WB_RF_ENABLE;
    logic        PC_LE;
    logic        IF_ID_LE;
    logic        ID_EX_NOP;
    logic [1:0]  FWD_A_SEL;
    logic [1:0]  FWD_B_SEL;
    logic        MDU_GO;
    logic        MDU_BUSY;
    logic        MDU_DONE;
`ifdef STALL_COUNTER_EN
    logic [31:0] STALL_COUNT;
`endif

    modport master (
        output ID_RS, ID_RT, ID_USES_RS, ID_USES_RT, ID_READS_HILO,
        output ID_MDU_START, ID_MDU_DIV,
        output EX_DEST, EX_RF_ENABLE, EX_LOAD_INSTR,
        output MEM_DEST, MEM_RF_ENABLE, WB_DEST, WB_RF_ENABLE,
        input  PC_LE, IF_ID_LE, ID_EX_NOP, FWD_A_SEL, FWD_B_SEL,
        input  MDU_GO, MDU_BUSY, MDU_DONE
`ifdef STALL_COUNTER_EN
        , input STALL_COUNT
`endif
    );

    modport slave (
        input  ID_RS, ID_RT, ID_USES_RS, ID_USES_RT, ID_READS_HILO,
        input  ID_MDU_START, ID_MDU_DIV,
        input  EX_DEST, EX_RF_ENABLE, EX_LOAD_INSTR,
        input  MEM_DEST, MEM_RF_ENABLE, WB_DEST, WB_RF_ENABLE,
        output PC_LE, IF_ID_LE, ID_EX_NOP, FWD_A_SEL, FWD_B_SEL,
        output MDU_GO, MDU_BUSY, MDU_DONE
`ifdef STALL_COUNTER_EN
        , output STALL_COUNT
`endif
    );

endinterface

// File: rtl/fwd_select.sv
// Operand forwarding select for one ID source register, priority EX > MEM > WB.
// A load in EX is never forwarded from EX; the load-use stall covers it.
module fwd_select
    import mips_pipe_pkg::*;
(
    input  logic [4:0] src,
    input  logic       uses,
    input  logic [4:0] ex_dest,
    input  logic       ex_rf_enable,
    input  logic       ex_load,
    input  logic [4:0] mem_dest,
    input  logic       mem_rf_enable,
    input  logic [4:0] wb_dest,
    input  logic       wb_rf_enable,
    output logic [1:0] sel
);

    logic valid_src;

    assign valid_src = uses && (src != REG_ZERO);

    always_comb begin
        sel = FWD_RF;
        if (valid_src && ex_rf_enable && !ex_load && (ex_dest == src)) begin
            sel = FWD_EX;
        end else if (valid_src && mem_rf_enable && (mem_dest == src)) begin
            sel = FWD_MEM;
        end else if (valid_src && wb_rf_enable && (wb_dest == src)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_stall_controller.sv
// Load-use / HI-LO hazard detection, operand forwarding and MDU sequencing for
// a 5-stage MIPS pipeline. Optional stall counter: define STALL_COUNTER_EN.
module hazard_stall_controller
    import mips_pipe_pkg::*;
#(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 8,
    parameter int CNT_W       = 4
) (
    input  logic                     Clk,
    input  logic                     Reset,
    hazard_stall_controller_if.slave hz
);

    mdu_state_t       state_reg;
    logic [CNT_W-1:0] count_reg;
    logic             done_reg;

    logic [4:0] src [2];
    logic       uses [2];
    logic       ex_hit [2];
    logic [1:0] sel [2];

    logic load_stall;
    logic mdu_stall;
    logic stall;
    logic busy;
    logic [CNT_W-1:0] start_count;

    assign src[0]  = hz.ID_RS;
    assign src[1]  = hz.ID_RT;
    assign uses[0] = hz.ID_USES_RS;
    assign uses[1] = hz.ID_USES_RT;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign ex_hit[gi] = uses[gi] && (hz.EX_DEST == src[gi]);

            fwd_select u_fwd (
                .src           (src[gi]),
                .uses          (uses[gi]),
                .ex_dest       (hz.EX_DEST),
                .ex_rf_enable  (hz.EX_RF_ENABLE),
                .ex_load       (hz.EX_LOAD_INSTR),
                .mem_dest      (hz.MEM_DEST),
                .mem_rf_enable (hz.MEM_RF_ENABLE),
                .wb_dest       (hz.WB_DEST),
                .wb_rf_enable  (hz.WB_RF_ENABLE),
                .sel           (sel[gi])
            );
        end
    endgenerate

    assign load_stall = hz.EX_LOAD_INSTR && hz.EX_RF_ENABLE &&
                        (hz.EX_DEST != REG_ZERO) && (ex_hit[0] || ex_hit[1]);
    assign busy       = (state_reg == RUN);
    assign mdu_stall  = busy && (hz.ID_READS_HILO || hz.ID_MDU_START);
    assign stall      = load_stall || mdu_stall;

    assign hz.PC_LE     = !stall;
    assign hz.IF_ID_LE  = !stall;
    assign hz.ID_EX_NOP = stall;
    assign hz.FWD_A_SEL = sel[0];
    assign hz.FWD_B_SEL = sel[1];
    // Gated by stall so a start held in ID by a hazard is issued exactly once.
    assign hz.MDU_GO    = (state_reg == IDLE) && hz.ID_MDU_START && !stall;
    assign hz.MDU_BUSY  = busy;
    assign hz.MDU_DONE  = done_reg;

    assign start_count = hz.ID_MDU_DIV ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg <= IDLE;
            count_reg <= '0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (hz.ID_MDU_START && !load_stall) begin
                        count_reg <= start_count;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    if (count_reg != '0) begin
                        count_reg <= count_reg - 1'b1;
                    end else begin
                        state_reg <= IDLE;
                        done_reg  <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef STALL_COUNTER_EN
    logic [31:0] stall_count_reg;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            stall_count_reg <= '0;
        end else if (stall) begin
            stall_count_reg <= stall_count_reg + 32'd1;
        end
    end

    assign hz.STALL_COUNT = stall_count_reg;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench for hazard_stall_controller: forwarding/stall vector table
// plus MDU sequences, checked through an expected-output scoreboard queue.
module tb_hazard_stall_controller;

    typedef struct packed {
        logic       rst;
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       uses_rs;
        logic       uses_rt;
        logic       reads_hilo;
        logic       mdu_start;
        logic       mdu_div;
        logic [4:0] ex_dest;
        logic       ex_rf;
        logic       ex_load;
        logic [4:0] mem_dest;
        logic       mem_rf;
        logic [4:0] wb_dest;
        logic       wb_rf;
    } in_t;

    typedef struct packed {
        logic       pc_le;
        logic       if_id_le;
        logic       nop;
        logic [1:0] fwd_a;
        logic [1:0] fwd_b;
        logic       go;
        logic       busy;
        logic       done;
    } out_t;

    typedef struct {
        in_t   vin;
        out_t  vexp;
        string name;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    out_t  exp_q[$];
    string name_q[$];

    int unsigned model_cnt = 0;
    logic        last_rst = 1'b1;
    logic        last_stall = 1'b0;

    hazard_stall_controller_if hz ();

    hazard_stall_controller #(
        .MULT_CYCLES (4),
        .DIV_CYCLES  (8),
        .CNT_W       (4)
    ) dut (
        .Clk   (clk),
        .Reset (rst),
        .hz    (hz)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    function automatic in_t idle_in();
        in_t i;
        i = '0;
        return i;
    endfunction

    function automatic out_t nominal();
        out_t o;
        o = '0;
        o.pc_le = 1'b1;
        o.if_id_le = 1'b1;
        return o;
    endfunction

    function automatic out_t stalled(input out_t o);
        out_t r;
        r = o;
        r.pc_le = 1'b0;
        r.if_id_le = 1'b0;
        r.nop = 1'b1;
        return r;
    endfunction

    task automatic apply(input in_t i);
        rst              = i.rst;
        hz.ID_RS         = i.id_rs;
        hz.ID_RT         = i.id_rt;
        hz.ID_USES_RS    = i.uses_rs;
        hz.ID_USES_RT    = i.uses_rt;
        hz.ID_READS_HILO = i.reads_hilo;
        hz.ID_MDU_START  = i.mdu_start;
        hz.ID_MDU_DIV    = i.mdu_div;
        hz.EX_DEST       = i.ex_dest;
        hz.EX_RF_ENABLE  = i.ex_rf;
        hz.EX_LOAD_INSTR = i.ex_load;
        hz.MEM_DEST      = i.mem_dest;
        hz.MEM_RF_ENABLE = i.mem_rf;
        hz.WB_DEST       = i.wb_dest;
        hz.WB_RF_ENABLE  = i.wb_rf;
    endtask

    task automatic check_pop();
        out_t  e;
        out_t  a;
        string nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a.pc_le    = hz.PC_LE;
        a.if_id_le = hz.IF_ID_LE;
        a.nop      = hz.ID_EX_NOP;
        a.fwd_a    = hz.FWD_A_SEL;
        a.fwd_b    = hz.FWD_B_SEL;
        a.go       = hz.MDU_GO;
        a.busy     = hz.MDU_BUSY;
        a.done     = hz.MDU_DONE;
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got pc_le=%b if_id_le=%b nop=%b fwd_a=%b fwd_b=%b go=%b busy=%b done=%b, expected pc_le=%b if_id_le=%b nop=%b fwd_a=%b fwd_b=%b go=%b busy=%b done=%b",
                     nm, a.pc_le, a.if_id_le, a.nop, a.fwd_a, a.fwd_b, a.go, a.busy, a.done,
                     e.pc_le, e.if_id_le, e.nop, e.fwd_a, e.fwd_b, e.go, e.busy, e.done);
        end else begin
            $display("ok   %s: pc_le=%b nop=%b fwd_a=%b fwd_b=%b go=%b busy=%b done=%b",
                     nm, a.pc_le, a.nop, a.fwd_a, a.fwd_b, a.go, a.busy, a.done);
        end
`ifdef STALL_COUNTER_EN
        checks++;
        if (hz.STALL_COUNT !== model_cnt) begin
            errors++;
            $display("FAIL %s_stall_count: got %0d, expected %0d", nm, hz.STALL_COUNT, model_cnt);
        end
`endif
    endtask

    // One clock: the previous inputs are sampled at the edge, new inputs are
    // driven just after it and outputs are compared on the falling edge.
    task automatic step(input in_t i, input out_t e, input string nm);
        @(posedge clk);
        #1;
        if (last_rst) model_cnt = 0;
        else if (last_stall) model_cnt = model_cnt + 1;
        apply(i);
        last_rst   = i.rst;
        last_stall = e.nop;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
        check_pop();
    endtask

    vec_t vecs[11];

    initial begin
        in_t  vi;
        out_t vo;

        apply(idle_in());
        rst = 1'b1;

        // Forwarding / load-stall table, all applied with the MDU idle.
        vi = idle_in(); vi.id_rs = 5; vi.uses_rs = 1;
        vi.ex_dest = 5; vi.ex_rf = 1; vi.mem_dest = 5; vi.mem_rf = 1; vi.wb_dest = 5; vi.wb_rf = 1;
        vo = nominal(); vo.fwd_a = 2'b01;
        vecs[0] = '{vi, vo, "fwd_prio_ex"};
        vi.ex_rf = 0; vo.fwd_a = 2'b10;
        vecs[1] = '{vi, vo, "fwd_prio_mem"};
        vi.mem_rf = 0; vo.fwd_a = 2'b11;
        vecs[2] = '{vi, vo, "fwd_prio_wb"};
        vi = idle_in(); vi.uses_rs = 1; vi.uses_rt = 1;
        vi.ex_rf = 1; vi.mem_rf = 1; vi.wb_rf = 1;
        vo = nominal();
        vecs[3] = '{vi, vo, "fwd_reg_zero"};
        vi = idle_in(); vi.id_rs = 9; vi.ex_dest = 9; vi.ex_rf = 1;
        vecs[4] = '{vi, vo, "fwd_rs_unused"};
        vi = idle_in(); vi.id_rs = 2; vi.uses_rs = 1; vi.id_rt = 7; vi.uses_rt = 1;
        vi.ex_dest = 7; vi.ex_rf = 1;
        vo = nominal(); vo.fwd_b = 2'b01;
        vecs[5] = '{vi, vo, "fwd_rt_ex"};
        vi = idle_in(); vi.id_rs = 6; vi.uses_rs = 1;
        vi.ex_dest = 6; vi.ex_rf = 1; vi.ex_load = 1; vi.mem_dest = 6; vi.mem_rf = 1;
        vo = stalled(nominal()); vo.fwd_a = 2'b10;
        vecs[6] = '{vi, vo, "load_in_ex_not_fwd"};
        vi = idle_in(); vi.uses_rt = 1; vi.ex_rf = 1; vi.ex_load = 1;
        vo = nominal();
        vecs[7] = '{vi, vo, "load_dest_zero"};
        vi = idle_in(); vi.id_rs = 4; vi.ex_dest = 4; vi.ex_rf = 1; vi.ex_load = 1;
        vecs[8] = '{vi, vo, "load_src_unused"};
        vi = idle_in(); vi.id_rs = 3; vi.uses_rs = 1; vi.id_rt = 4; vi.uses_rt = 1;
        vi.mem_dest = 3; vi.mem_rf = 1; vi.wb_dest = 4; vi.wb_rf = 1;
        vo = nominal(); vo.fwd_a = 2'b10; vo.fwd_b = 2'b11;
        vecs[9] = '{vi, vo, "fwd_mixed"};
        vi = idle_in(); vi.id_rt = 8; vi.uses_rt = 1; vi.ex_dest = 8; vi.ex_load = 1;
        vo = nominal();
        vecs[10] = '{vi, vo, "load_no_rf_enable"};

        vi = idle_in(); vi.rst = 1;
        step(vi, nominal(), "reset_state");
        step(idle_in(), nominal(), "reset_release");

        for (int k = 0; k < 11; k++) begin
            step(vecs[k].vin, vecs[k].vexp, vecs[k].name);
        end

        // Load-use: one stall cycle, then the load forwards from MEM.
        vi = idle_in(); vi.ex_load = 1; vi.ex_rf = 1; vi.ex_dest = 8; vi.id_rt = 8; vi.uses_rt = 1;
        step(vi, stalled(nominal()), "load_use_stall");
        vi = idle_in(); vi.mem_dest = 8; vi.mem_rf = 1; vi.ex_dest = 8; vi.id_rt = 8; vi.uses_rt = 1;
        vo = nominal(); vo.fwd_b = 2'b10;
        step(vi, vo, "load_use_mem_fwd");

        // Start held by a load-use stall is not issued, then issues once.
        vi = idle_in(); vi.ex_load = 1; vi.ex_rf = 1; vi.ex_dest = 8; vi.id_rs = 8; vi.uses_rs = 1;
        vi.mdu_start = 1;
        step(vi, stalled(nominal()), "start_blocked_by_load");
        vi = idle_in(); vi.mdu_start = 1;
        vo = nominal(); vo.go = 1;
        step(vi, vo, "mult_go");
        for (int c = 1; c <= 4; c++) begin
            vi = idle_in();
            vo = nominal(); vo.busy = 1;
            if (c == 2) begin
                vi.mdu_start = 1;
                vo = stalled(vo);
            end
            step(vi, vo, $sformatf("mult_busy_c%0d", c));
        end
        // Back-to-back start accepted in the DONE cycle.
        vi = idle_in(); vi.mdu_start = 1;
        vo = nominal(); vo.go = 1; vo.done = 1;
        step(vi, vo, "mult_done_b2b_go");
        for (int c = 1; c <= 4; c++) begin
            vo = nominal(); vo.busy = 1;
            step(idle_in(), vo, $sformatf("mult2_busy_c%0d", c));
        end
        vi = idle_in(); vi.reads_hilo = 1;
        vo = nominal(); vo.done = 1;
        step(vi, vo, "mult2_done_hilo_free");
        step(idle_in(), nominal(), "mult2_after_done");

        // Load-use stall plus a divide with HI/LO read held from cycle 2.
        vi = idle_in(); vi.rst = 1;
        step(vi, nominal(), "reset_before_div");
        vi = idle_in(); vi.ex_load = 1; vi.ex_rf = 1; vi.ex_dest = 8; vi.id_rt = 8; vi.uses_rt = 1;
        step(vi, stalled(nominal()), "div_pre_load_stall");
        vi = idle_in(); vi.mdu_start = 1; vi.mdu_div = 1;
        vo = nominal(); vo.go = 1;
        step(vi, vo, "div_go");
        for (int c = 1; c <= 8; c++) begin
            vi = idle_in();
            vo = nominal(); vo.busy = 1;
            if (c >= 2) begin
                vi.reads_hilo = 1;
                vo = stalled(vo);
            end
            step(vi, vo, $sformatf("div_busy_c%0d", c));
        end
        vi = idle_in(); vi.reads_hilo = 1;
        vo = nominal(); vo.done = 1;
        step(vi, vo, "div_done_release");
`ifdef STALL_COUNTER_EN
        checks++;
        if (hz.STALL_COUNT !== 32'd8) begin
            errors++;
            $display("FAIL stall_count_total: got %0d, expected 8", hz.STALL_COUNT);
        end
`endif
        step(idle_in(), nominal(), "div_after_done");

        // Reset during a divide abandons it without a DONE strobe.
        vi = idle_in(); vi.mdu_start = 1; vi.mdu_div = 1;
        vo = nominal(); vo.go = 1;
        step(vi, vo, "rdiv_go");
        for (int c = 1; c <= 2; c++) begin
            vo = nominal(); vo.busy = 1;
            step(idle_in(), vo, $sformatf("rdiv_busy_c%0d", c));
        end
        vi = idle_in(); vi.rst = 1;
        vo = nominal(); vo.busy = 1;
        step(vi, vo, "rdiv_reset_c3");
        for (int c = 4; c <= 12; c++) begin
            step(idle_in(), nominal(), $sformatf("rdiv_idle_c%0d", c));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
Sequencing controller for the MIPS 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Detects load-use hazards and generates operand forwarding selects.
- Sequences a multi-cycle multiply/divide unit (MDU) that writes HI/LO.
- Drives PC/IF-ID load enables and a bubble (NOP) select that zeroes the ID/EX control inputs.
- Sits beside the ID stage and observes the destination fields of EX, MEM and WB.

Parameters:
- MULT_CYCLES, 4, MDU busy cycles for mult/multu (≥1)
- DIV_CYCLES, 8, MDU busy cycles for div/divu (≥1)
- CNT_W, 4, MDU down-counter width; must hold max(MULT_CYCLES, DIV_CYCLES)-1

Ports:
- Clk  in  1  pipeline clock, rising edge
- Reset  in  1  synchronous, active-high
- ID_RS  in  5  rs field of instruction in ID
- ID_RT  in  5  rt field of instruction in ID
- ID_USES_RS  in  1  ID instruction reads rs
- ID_USES_RT  in  1  ID instruction reads rt
- ID_READS_HILO  in  1  ID instruction is mfhi/mflo
- ID_MDU_START  in  1  ID instruction is mult/multu/div/divu
- ID_MDU_DIV  in  1  qualifies ID_MDU_START: 1 = divide
- EX_DEST  in  5  destination register in EX
- EX_RF_ENABLE  in  1  EX instruction writes the register file
- EX_LOAD_INSTR  in  1  EX instruction is a load
- MEM_DEST  in  5  destination register in MEM
- MEM_RF_ENABLE  in  1  MEM instruction writes the register file
- WB_DEST  in  5  destination register in WB
- WB_RF_ENABLE  in  1  WB instruction writes the register file
- PC_LE  out  1  PC load enable
- IF_ID_LE  out  1  IF/ID register LE
- ID_EX_NOP  out  1  1 = feed zeros into the ID/EX control inputs
- FWD_A_SEL  out  2  rs operand source: 00 RF, 01 EX, 10 MEM, 11 WB
- FWD_B_SEL  out  2  rt operand source, same encoding
- MDU_GO  out  1  start pulse to the MDU
- MDU_BUSY  out  1  MDU operation in flight
- MDU_DONE  out  1  registered one-cycle HI/LO write strobe
- STALL_COUNT  out  32  only when STALL_COUNTER_EN is defined

Behaviour:
- Clocking and reset: one clock, Clk; Reset is synchronous and active-high.
- Reset effect:
  - state=IDLE, counter=0, MDU_DONE=0.
  - The combinational outputs therefore settle to PC_LE=1, IF_ID_LE=1, ID_EX_NOP=0, MDU_GO=0, MDU_BUSY=0.
  - FWD_A_SEL/FWD_B_SEL follow the inputs.
  - Reset during RUN abandons the operation; no MDU_DONE is produced.
- Forwarding (combinational), shown for rs; rt is identical:
  - Priority EX > MEM > WB.
  - A stage matches when its RF_ENABLE=1, its DEST==ID_RS, ID_RS!=0 and ID_USES_RS=1.
  - EX matches only if EX_LOAD_INSTR=0; a load in EX causes a stall instead.
  - No match → 00.
- load_stall (combinational):
  - Asserted when EX_LOAD_INSTR & EX_RF_ENABLE & EX_DEST!=0 and EX_DEST matches a used ID source.
  - Lasts exactly one cycle: the next cycle the load is in MEM and is forwarded via select 10.
- mdu_stall: MDU_BUSY & (ID_READS_HILO | ID_MDU_START).
- stall = load_stall | mdu_stall, which drives PC_LE = IF_ID_LE = ~stall and ID_EX_NOP = stall.
- MDU FSM states:
  - IDLE:
    - When ID_MDU_START & ~load_stall: MDU_GO=1.
    - counter ← (ID_MDU_DIV ? DIV_CYCLES : MULT_CYCLES) - 1.
    - Next state RUN.
  - RUN:
    - MDU_BUSY=1.
    - If counter!=0, counter decrements.
    - If counter==0: next state IDLE, and MDU_DONE=1 in the following cycle.
- Cycle accounting: busy for exactly N cycles after the start edge; MDU_DONE coincides with the first IDLE cycle.
- MDU_GO is combinational, so it is suppressed whenever stall=1; a stalled start is never issued twice.
- Boundaries:
  - Last RUN cycle: mdu_stall is still asserted.
  - Release happens in the next (IDLE) cycle.
  - A back-to-back start is accepted in that cycle while MDU_DONE=1.
  - An mfhi/mflo issued in the MDU_DONE cycle is not stalled; the datapath forwards MDU results to HI/LO reads in that cycle.

Optional Feature:
- Macro: STALL_COUNTER_EN.
- Defined:
  - Adds the 32-bit STALL_COUNT port.
  - Increments on every cycle with stall=1; wraps at 2^32-1 to 0.
  - Cleared by Reset.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Shared package mips_pipe_pkg:
  - FWD_RF/FWD_EX/FWD_MEM/FWD_WB 2-bit constants.
  - MDU state encoding (IDLE=0, RUN=1).
  - REG_ZERO=5'd0.
- Natural sub-module: fwd_select.
  - Purely combinational.
  - Instantiated twice, for rs and rt.
- The FSM and stall logic live in the top.

Test Plan:
- Forwarding priority: EX_DEST=MEM_DEST=WB_DEST=5 with all RF_ENABLE=1, ID_RS=5 and ID_USES_RS=1 → FWD_A_SEL=01. Drop EX_RF_ENABLE → 10. Then drop MEM_RF_ENABLE → 11. Set ID_RS=0 → 00.
- Load-use: EX_LOAD_INSTR=1, EX_DEST=8, ID_RT=8, ID_USES_RT=1 → exactly one cycle of PC_LE=0, IF_ID_LE=0, ID_EX_NOP=1. Next cycle with MEM_DEST=8 → FWD_B_SEL=10 and no stall.
- Multiply: ID_MDU_START=1, ID_MDU_DIV=0 → MDU_GO pulses one cycle, MDU_BUSY=1 for 4 cycles, MDU_DONE high in cycle 5.
- HI/LO hazard: during a divide (DIV_CYCLES=8), hold ID_READS_HILO=1 from cycle 2 → stall through cycle 8; release and MDU_DONE=1 in cycle 9.
- Reset mid-divide: Reset=1 at busy cycle 3 → next cycle MDU_BUSY=0, PC_LE=1, and MDU_DONE never asserts.
- With STALL_COUNTER_EN defined: the load-use stall plus the divide stall above → STALL_COUNT=8. Reset → 0.
